seq_step_ctrl: RTL and testbench
================================

// Module: seq_step_ctrl
// PURPOSE
//  Step controller for the 3-bit sequence-detector FSM. Replaces raw button clocking:
//  debounces BTND on the system clock and issues one-cycle step_en strobes, each carrying
//  one serial input bit. Manual mode: bit = SW1 at a debounced press. Auto mode: bits replay
//  from a fixed PATTERN at a fixed tick rate. Counts detector hits for LED display.
// PARAMETERS
//  DEB_CNT   1000000       consecutive stable cycles required to accept a press or release (>=1)
//  TICK_CNT  50000000      auto-mode cycles between steps (>=2)
//  PAT_W     8             auto pattern length, bits
//  PATTERN   8'b1010_1101  auto bit stream, sent MSB first, then wraps
//  HIT_W     4             hit counter width
// PORTS
//  clk       in   1      system clock; all logic on rising edge
//  reset     in   1      synchronous, active-high
//  BTND      in   1      raw step button, asynchronous, bouncy
//  SW1       in   1      manual serial input bit, asynchronous
//  SW0       in   1      mode select: 0 = manual, 1 = auto; asynchronous
//  hit       in   1      detector match flag (detector led0)
//  step_en   out  1      one-cycle strobe: detector advances one state
//  step_bit  out  1      serial bit for that step; valid while step_en=1, otherwise holds
//  hit_cnt   out  HIT_W  saturating count of hits
//  led_mode  out  1      registered copy of synchronised SW0
// BEHAVIOUR
//  Reset: step_en=0, step_bit=0, hit_cnt=0, led_mode=0; FSM=IDLE; debounce ctr=0; tick ctr=0; ptr=PAT_W-1.
//  Reset has priority over every other event in the same cycle.
//  BTND, SW1 and SW0 pass through 2-flop synchronisers (2 cycles latency); all logic uses the synced copies.
//  Manual FSM (active when mode=0):
//   IDLE     : btn=1 -> PRESS_DB, ctr=1.
//   PRESS_DB : btn=1 -> ctr++; ctr reaches DEB_CNT -> STEP. btn=0 -> IDLE, ctr=0 (bounce rejected).
//   STEP     : one cycle. step_en=1, step_bit=synced SW1 sampled this cycle. -> HELD.
//   HELD     : btn=0 -> REL_DB, ctr=1. Holding never issues another step.
//   REL_DB   : btn=0 -> ctr++; ctr reaches DEB_CNT -> IDLE. btn=1 -> HELD, ctr=0.
//   Latency: step_en is high 2+DEB_CNT+1 cycles after the BTND rising edge, for a clean press.
//  Auto mode (mode=1): BTND ignored. Tick ctr counts 0..TICK_CNT-1.
//   At TICK_CNT-1: step_en=1, step_bit=PATTERN[ptr]; ptr decrements, PAT_W-1 follows 0 (wrap).
//   First auto step occurs TICK_CNT cycles after the mode becomes 1.
//  Mode change (either direction): same cycle -> FSM=IDLE, both ctrs=0, ptr=PAT_W-1; no step is issued.
//   A press in progress is aborted. In manual mode, a button held across the change re-debounces from IDLE.
//  step_en is never high on two consecutive cycles.
//  Hit count: in the cycle after each step_en, if hit=1, hit_cnt++. Saturates at 2^HIT_W-1 (no wrap).
//   hit is ignored in every other cycle.
//  Counter widths: $clog2 of the terminal value +1. No truncation warnings are accepted.
// STRUCTURE
//  Package seq_ctrl_pkg: state encoding (IDLE, PRESS_DB, STEP, HELD, REL_DB; 3 bits); MODE_MANUAL/MODE_AUTO.
//  Sub-module sync2: 2-flop synchroniser, instantiated 3 times. FSM, tick ctr, pattern ptr and hit ctr stay inline.
// TESTING (bench parameters: DEB_CNT=4, TICK_CNT=3, PATTERN=8'b1010_1101, HIT_W=4)
//  1. Reset held 3 cycles, then released -> all outputs 0; no step_en for 20 idle cycles.
//  2. SW1=1; BTND 0->1 held 12 cycles -> exactly one step_en, step_bit=1, 7 cycles after the edge.
//     Release -> no further step_en.
//  3. BTND bounces 1,1,0,1,0 then is stable high -> no step during the bounce; one step after 4 stable cycles.
//     Release bounce -> no extra step.
//  4. SW0=1 for 30 cycles -> step_en every 3rd cycle.
//     step_bit sequence = 1,0,1,0,1,1,0,1, then 1,0,... (wraps).
//  5. Auto mode with hit=1 constantly -> hit_cnt counts 1..15, then stays 15 for later steps.
//     Reset -> hit_cnt=0.
//  6. Reset asserted in PRESS_DB, and separately SW0 toggled in PRESS_DB -> no step_en; FSM=IDLE.
//     Step only after a fresh full debounce.

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: state encoding and mode constants shared by the step controller
package seq_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, PRESS_DB, STEP, HELD, REL_DB} state_t;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for one asynchronous input bit
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end
endmodule

// File: rtl/seq_step_ctrl.sv
// seq_step_ctrl: debounced manual / timed auto step strobes for the sequence detector, plus hit counter
module seq_step_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int              DEB_CNT  = 1000000,
  parameter int              TICK_CNT = 50000000,
  parameter int              PAT_W    = 8,
  parameter logic [PAT_W-1:0] PATTERN = 8'b1010_1101,
  parameter int              HIT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BTND,
  input  logic             SW1,
  input  logic             SW0,
  input  logic             hit,
  output logic             step_en,
  output logic             step_bit,
  output logic [HIT_W-1:0] hit_cnt,
  output logic             led_mode
);
  localparam int DW = $clog2(DEB_CNT) + 1;
  localparam int TW = $clog2(TICK_CNT) + 1;
  localparam int PW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_CNT);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_CNT - 1);
  localparam logic [PW-1:0]    PTR_TOP   = PW'(PAT_W - 1);
  localparam logic [HIT_W-1:0] HIT_MAX   = '1;
  logic btn_s, sw1_s, mode_s;
  state_t state_q, state_d;
  logic [DW-1:0] ctr_q, ctr_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic mode_q, step_en_q, step_en_d, step_bit_q, step_bit_d, hit_win_q;
  sync2 u_sync_btn (.clk(clk), .reset(reset), .d(BTND), .q(btn_s));
  sync2 u_sync_sw1 (.clk(clk), .reset(reset), .d(SW1),  .q(sw1_s));
  sync2 u_sync_sw0 (.clk(clk), .reset(reset), .d(SW0),  .q(mode_s));
  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    tick_d     = tick_q;
    ptr_d      = ptr_q;
    step_en_d  = 1'b0;
    step_bit_d = step_bit_q;
    // A mode flip in either direction restarts everything and suppresses any pending step
    if (mode_s != mode_q) begin
      state_d = IDLE;
      ctr_d   = '0;
      tick_d  = '0;
      ptr_d   = PTR_TOP;
    end else if (mode_q == MODE_AUTO) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
      if (tick_q == TICK_LAST) begin
        step_en_d  = 1'b1;
        step_bit_d = PATTERN[ptr_q];
        ptr_d      = (ptr_q == '0) ? PTR_TOP : ptr_q - 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: if (btn_s) begin
          state_d = (DEB_CNT == 1) ? STEP : PRESS_DB;
          ctr_d   = (DEB_CNT == 1) ? '0 : DW'(1);
        end
        PRESS_DB: begin
          state_d = !btn_s ? IDLE : (ctr_q + 1'b1 == DEB_LAST) ? STEP : PRESS_DB;
          ctr_d   = (!btn_s || ctr_q + 1'b1 == DEB_LAST) ? '0 : ctr_q + 1'b1;
        end
        STEP: begin
          step_en_d  = 1'b1;
          step_bit_d = sw1_s;
          state_d    = HELD;
          ctr_d      = '0;
        end
        HELD: if (!btn_s) begin
          state_d = (DEB_CNT == 1) ? IDLE : REL_DB;
          ctr_d   = (DEB_CNT == 1) ? '0 : DW'(1);
        end
        REL_DB: begin
          state_d = btn_s ? HELD : (ctr_q + 1'b1 == DEB_LAST) ? IDLE : REL_DB;
          ctr_d   = (btn_s || ctr_q + 1'b1 == DEB_LAST) ? '0 : ctr_q + 1'b1;
        end
        default: begin
          state_d = IDLE;
          ctr_d   = '0;
        end
      endcase
    end
    hit_cnt_d = (hit_win_q && hit && hit_cnt_q != HIT_MAX) ? hit_cnt_q + 1'b1 : hit_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      tick_q     <= '0;
      ptr_q      <= PTR_TOP;
      mode_q     <= MODE_MANUAL;
      step_en_q  <= 1'b0;
      step_bit_q <= 1'b0;
      hit_win_q  <= 1'b0;
      hit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ctr_q      <= ctr_d;
      tick_q     <= tick_d;
      ptr_q      <= ptr_d;
      mode_q     <= mode_s;
      step_en_q  <= step_en_d;
      step_bit_q <= step_bit_d;
      hit_win_q  <= step_en_q;
      hit_cnt_q  <= hit_cnt_d;
    end
  end
  assign step_en  = step_en_q;
  assign step_bit = step_bit_q;
  assign hit_cnt  = hit_cnt_q;
  assign led_mode = mode_q;
endmodule

// File: tb/tb_seq_step_ctrl.sv
// tb_seq_step_ctrl: directed scenarios plus random stimulus against a stable-run-length reference model
module tb_seq_step_ctrl;
  localparam int DEB = 4, TICK = 3, PW = 8, HW = 4;
  localparam logic [7:0] PAT = 8'b1010_1101;
  logic clk = 1'b0, reset = 1'b1, BTND = 1'b0, SW1 = 1'b0, SW0 = 1'b0, hit = 1'b0;
  logic step_en, step_bit, led_mode;
  logic [HW-1:0] hit_cnt;
  int total = 0, bad = 0, steps = 0;
  logic bitq[$];
  logic [7:0] pat_bits = PAT;
  logic mb1, mb2, ms1, ms2, mm1, mm2, m_led, e_en, e_bit, en_prev;
  int e_hit, run, age, idx;
  bit armed, pend;
  always #5 clk = ~clk;
  seq_step_ctrl #(.DEB_CNT(DEB), .TICK_CNT(TICK), .PAT_W(PW), .PATTERN(PAT), .HIT_W(HW)) dut (
    .clk(clk), .reset(reset), .BTND(BTND), .SW1(SW1), .SW0(SW0), .hit(hit),
    .step_en(step_en), .step_bit(step_bit), .hit_cnt(hit_cnt), .led_mode(led_mode)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask
  // Expected outputs for the next cycle: presses/releases accepted after DEB stable synced samples,
  // auto steps every TICK cycles counted from the mode flip.
  task automatic model_eval();
    logic n_en, n_bit;
    int nh;
    if (reset) begin
      {mb1, mb2, ms1, ms2, mm1, mm2, m_led, e_en, e_bit, en_prev} = '0;
      e_hit = 0; run = 0; age = 0; idx = 0; armed = 1; pend = 0;
      return;
    end
    nh = (en_prev && hit && e_hit != 15) ? e_hit + 1 : e_hit;
    n_en = 1'b0;
    n_bit = e_bit;
    if (mm2 != m_led) begin
      armed = 1; run = 0; pend = 0; age = 0; idx = 0;
    end else if (mm2) begin
      age++;
      if (age == TICK) begin
        age = 0; n_en = 1'b1; n_bit = pat_bits[PW-1-idx]; idx = (idx + 1) % PW;
      end
    end else if (pend) begin
      pend = 0; n_en = 1'b1; n_bit = ms2; armed = 0; run = 0;
    end else if (armed) begin
      run = mb2 ? run + 1 : 0;
      if (run == DEB) begin pend = 1; run = 0; end
    end else begin
      run = !mb2 ? run + 1 : 0;
      if (run == DEB) begin armed = 1; run = 0; end
    end
    en_prev = e_en; e_en = n_en; e_bit = n_bit; e_hit = nh; m_led = mm2;
    mb2 = mb1; mb1 = BTND; ms2 = ms1; ms1 = SW1; mm2 = mm1; mm1 = SW0;
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      model_eval();
      @(posedge clk); #1;
      check("step_en", step_en, e_en);
      check("step_bit", step_bit, e_bit);
      check("hit_cnt", hit_cnt, e_hit);
      check("led_mode", led_mode, m_led);
      if (step_en === 1'b1) begin steps++; bitq.push_back(step_bit); end
    end
  endtask
  task automatic rcyc(input int n = 1);
    repeat (n) begin hit = 1'($urandom); cyc(1); end
  endtask
  initial begin
    int s0, lat;
    logic b3 [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic exp4 [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    cyc(3);
    check("rst_hit", hit_cnt, 0);
    reset = 1'b0;
    cyc(20);
    check("idle_steps", steps, 0);
    // clean manual press
    SW1 = 1'b1; BTND = 1'b1; lat = -1; s0 = steps;
    for (int i = 1; i <= 12; i++) begin cyc(1); if (step_en && lat < 0) lat = i; end
    check("press_lat", lat, 7);
    check("press_bit", step_bit, 1);
    BTND = 1'b0; cyc(12);
    check("press_steps", steps - s0, 1);
    // bouncy press and release
    SW1 = 1'b0; s0 = steps;
    for (int i = 0; i < 5; i++) begin BTND = b3[i]; cyc(1); end
    check("bounce_none", steps - s0, 0);
    BTND = 1'b1; cyc(12);
    check("bounce_one", steps - s0, 1);
    check("bounce_bit", step_bit, 0);
    for (int i = 0; i < 5; i++) begin BTND = ~b3[i]; cyc(1); end
    BTND = 1'b0; cyc(12);
    check("bounce_rel", steps - s0, 1);
    // auto replay
    bitq.delete(); s0 = steps; SW0 = 1'b1; lat = -1;
    for (int i = 1; i <= 36; i++) begin cyc(1); if (step_en && lat < 0) lat = i; end
    check("auto_first", lat, 6);
    check("auto_cnt", steps - s0, 11);
    for (int i = 0; i < 10; i++) check("auto_bit", (i < bitq.size()) ? bitq[i] : 1'bx, exp4[i]);
    // hit saturation
    hit = 1'b1; cyc(60);
    check("hit_sat", hit_cnt, 15);
    SW0 = 1'b0; hit = 1'b0; reset = 1'b1; cyc(2);
    check("hit_reset", hit_cnt, 0);
    reset = 1'b0; cyc(4);
    // reset during press debounce
    BTND = 1'b1; s0 = steps; cyc(4);
    reset = 1'b1; cyc(1); reset = 1'b0; lat = -1;
    check("rst_abort", steps - s0, 0);
    for (int i = 1; i <= 12; i++) begin cyc(1); if (step_en && lat < 0) lat = i; end
    check("rst_relat", lat, 7);
    BTND = 1'b0; cyc(10);
    // mode glitch during press debounce
    BTND = 1'b1; s0 = steps; cyc(3);
    SW0 = 1'b1; lat = -1;
    for (int i = 1; i <= 14; i++) begin
      cyc(1);
      SW0 = 1'b0;
      if (step_en && lat < 0) lat = i;
    end
    check("mode_relat", lat, 9);
    check("mode_steps", steps - s0, 1);
    BTND = 1'b0; cyc(10);
    // random mix of presses, bounces, auto runs and resets
    for (int s = 0; s < 80; s++) begin
      int kind = int'($urandom_range(0, 9));
      if (kind < 6) begin
        SW0 = 1'b0; SW1 = 1'($urandom);
        repeat ($urandom_range(0, 4)) begin BTND = 1'($urandom); rcyc(1); end
        BTND = 1'b1; rcyc(int'($urandom_range(1, 10)));
        repeat ($urandom_range(0, 4)) begin BTND = 1'($urandom); rcyc(1); end
        BTND = 1'b0; rcyc(int'($urandom_range(1, 10)));
      end else if (kind < 9) begin
        SW0 = 1'b1;
        repeat ($urandom_range(1, 40)) begin BTND = 1'($urandom); rcyc(1); end
      end else begin
        reset = 1'b1; rcyc(1); reset = 1'b0;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
